// File: rtl/rob_marker_pkg.sv
// Shared types and constants for the ROB phase-marker tracker.
// Optional build macro: ROB_MARKER_PC_CAPTURE_EN adds the enqueue PC to each event record.
package rob_marker_pkg;

    // Markers are "slti x0,x0,k": only inst[23:20] (k) is free, everything else is fixed.
    localparam logic [31:0] MARKER_MASK  = 32'hFF0F_FFFF;
    localparam logic [31:0] MARKER_MATCH = 32'h0000_2013;
    localparam logic [3:0]  MARKER_MAX   = 4'd13;

    localparam int CYCLE_W    = 64;
    localparam int PC_STORE_W = 64;

    typedef enum logic [2:0] {
        PH_VCTM  = 3'd0,
        PH_DELAY = 3'd1,
        PH_TEXE  = 3'd2,
        PH_LEAK  = 3'd3,
        PH_INIT  = 3'd4,
        PH_BIM   = 3'd5,
        PH_TRAIN = 3'd6,
        PH_NONE  = 3'd7
    } phase_e;

    typedef struct packed {
        logic [3:0]         id;
        logic               commit;
        logic [CYCLE_W-1:0] cycle;
`ifdef ROB_MARKER_PC_CAPTURE_EN
        logic [PC_STORE_W-1:0] pc;
`endif
    } marker_evt_t;

    function automatic logic is_marker(input logic [31:0] inst);
        return ((inst & MARKER_MASK) == MARKER_MATCH) && (inst[23:20] <= MARKER_MAX);
    endfunction

endpackage

// File: rtl/rob_marker_tracker_if.sv
// Event stream from the marker tracker to its consumer (valid/ready handshake).
interface rob_marker_tracker_if #(
    parameter int PC_W = 40
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [3:0]      evt_id;
    logic            evt_commit;
    logic [63:0]     evt_cycle;
    logic [PC_W-1:0] evt_pc;

    modport master (
        output evt_valid, evt_id, evt_commit, evt_cycle, evt_pc,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_id, evt_commit, evt_cycle, evt_pc,
        output evt_ready
    );
endinterface

// File: rtl/rob_marker_fifo.sv
// Two-write / one-read FIFO; head comes straight from storage registers.
// Writers must use port 0 before port 1 (w1_en implies w0_en).
module rob_marker_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [68:0]
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     w0_en,
    input  T                         w0_data,
    input  logic                     w1_en,
    input  T                         w1_data,
    input  logic                     pop,
    output logic                     head_valid,
    output T                         head_data,
    output logic [$clog2(DEPTH):0]   free_slots
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  wr_ptr_nx;
    logic [AW:0]    count;
    logic           do_pop;

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign do_pop     = head_valid & pop;
    assign wr_ptr_nx  = wr_ptr + AW'(1);
    // A same-cycle pop frees the head slot for the incoming writes.
    assign free_slots = (AW+1)'(DEPTH) - count + (AW+1)'(do_pop);

    // Storage write: port 0 at the tail, port 1 right behind it.
    always_ff @(posedge clock) begin
        if (w0_en) mem[wr_ptr]    <= w0_data;
        if (w1_en) mem[wr_ptr_nx] <= w1_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(w0_en) + AW'(w1_en);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(w0_en) + (AW+1)'(w1_en) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rob_marker_tracker.sv
// Phase-marker monitor on ROB slot-0 enqueue/commit: timestamps markers into an
// event FIFO, counts dropped events and tracks the committed attack phase.
// Optional build macro: ROB_MARKER_PC_CAPTURE_EN stores enq_pc per event.
module rob_marker_tracker
    import rob_marker_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 40,
    parameter int DROP_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enq_valid,
    input  logic [31:0]            enq_inst,
    input  logic [PC_W-1:0]        enq_pc,
    input  logic                   commit_valid,
    input  logic [31:0]            commit_inst,
    rob_marker_tracker_if.master   evt,
    output logic [2:0]             phase,
    output logic                   phase_active,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   proto_err
);
    localparam int FW = $clog2(DEPTH) + 1;
    localparam logic [FW-1:0] ONE_SLOT  = FW'(1);
    localparam logic [FW-1:0] TWO_SLOTS = FW'(2);

    logic [63:0]       cycle_q;
    logic              cm, em;
    logic              take_c, take_e;
    logic              w0_en, w1_en;
    marker_evt_t       c_evt, e_evt, w0_data, w1_data, head;
    logic              head_valid;
    logic [FW-1:0]     free_slots;
    logic [1:0]        lost;
    logic [DROP_W:0]   drop_sum;
    phase_e            state_q, state_d, start_p;
    logic              err_set;

    assign cm      = commit_valid & is_marker(commit_inst);
    assign em      = enq_valid & is_marker(enq_inst);
    assign start_p = phase_e'(commit_inst[23:21]);

    // Build the candidate event records for this cycle.
    always_comb begin
        c_evt        = '0;
        c_evt.id     = commit_inst[23:20];
        c_evt.commit = 1'b1;
        c_evt.cycle  = cycle_q;
        e_evt        = '0;
        e_evt.id     = enq_inst[23:20];
        e_evt.cycle  = cycle_q;
`ifdef ROB_MARKER_PC_CAPTURE_EN
        e_evt.pc[PC_W-1:0] = enq_pc;
`endif
    end

    // Admission: commit event has priority for the last free slot; pack accepted events onto port 0 first.
    always_comb begin
        take_c = 1'b0;
        take_e = 1'b0;
        if (free_slots >= TWO_SLOTS) begin
            take_c = cm;
            take_e = em;
        end else if (free_slots == ONE_SLOT) begin
            take_c = cm;
            take_e = em & ~cm;
        end
        w0_en   = take_c | take_e;
        w0_data = take_c ? c_evt : e_evt;
        w1_en   = take_c & take_e;
        w1_data = e_evt;
        lost    = {1'b0, cm} + {1'b0, em} - {1'b0, take_c} - {1'b0, take_e};
    end

    rob_marker_fifo #(
        .DEPTH (DEPTH),
        .T     (marker_evt_t)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .w0_en      (w0_en),
        .w0_data    (w0_data),
        .w1_en      (w1_en),
        .w1_data    (w1_data),
        .pop        (evt.evt_ready),
        .head_valid (head_valid),
        .head_data  (head),
        .free_slots (free_slots)
    );

    assign evt.evt_valid  = head_valid;
    assign evt.evt_id     = head.id;
    assign evt.evt_commit = head.commit;
    assign evt.evt_cycle  = head.cycle;
`ifdef ROB_MARKER_PC_CAPTURE_EN
    logic unused_pc_hi;
    assign unused_pc_hi = ^head.pc;
    assign evt.evt_pc   = head.pc[PC_W-1:0];
`else
    logic unused_pc;
    assign unused_pc  = ^enq_pc;
    assign evt.evt_pc = '0;
`endif

    // Free-running timestamp counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cycle_q <= '0;
        else          cycle_q <= cycle_q + 64'd1;
    end

    assign drop_sum = {1'b0, drop_count} + (DROP_W+1)'(lost);

    // Saturating count of events lost to a full FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)             drop_count <= '0;
        else if (drop_sum[DROP_W]) drop_count <= '1;
        else                       drop_count <= drop_sum[DROP_W-1:0];
    end

    // Phase state register and sticky protocol error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PH_NONE;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) proto_err <= 1'b1;
        end
    end

    // Phase next-state: commit markers only; even k starts a phase, odd k ends it.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        if (cm) begin
            if (!commit_inst[20]) begin
                if (state_q != PH_NONE) err_set = 1'b1;
                state_d = start_p;
            end else if (state_q == start_p) begin
                state_d = PH_NONE;
            end else begin
                err_set = 1'b1;
            end
        end
    end

    assign phase        = state_q;
    assign phase_active = (state_q != PH_NONE);
endmodule

// File: doc/rob_marker_tracker.md
# rob_marker_tracker

Synthesizable monitor that sits directly downstream of the BOOM ROB slot-0 enqueue and commit ports. It decodes the phase-marker instructions (`slti x0,x0,k`, encoding 32'h00k02013, k = 0..13) and timestamps each one with a free-running cycle counter. Each marker is queued as an event record for the testbench to drain. The block also tracks the currently committed attack phase (INIT, TRAIN, BIM, VCTM, DELAY, TEXE, LEAK) so taint and coverage logic can qualify on it.

## Interface
- DEPTH, default 16: event FIFO entries; power of two, ≥ 4.
- PC_W, default 40: width of the enqueue PC.
- DROP_W, default 16: width of the saturating drop counter.
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- enq_valid  in  1  ROB slot-0 enqueue valid.
- enq_inst  in  32  enqueued uop debug_inst.
- enq_pc  in  PC_W  enqueued uop debug_pc.
- commit_valid  in  1  ROB slot-0 commit valid.
- commit_inst  in  32  committed uop debug_inst.
- evt_valid  out  1  event available at FIFO head.
- evt_ready  in  1  consumer accepts head.
- evt_id  out  4  marker index k (0..13).
- evt_commit  out  1  1 = seen at commit, 0 = seen at enqueue.
- evt_cycle  out  64  cycle-counter value when the marker was observed.
- evt_pc  out  PC_W  enqueue PC; 0 for commit events.
- phase  out  3  current committed phase; 7 = NONE.
- phase_active  out  1  phase != NONE.
- drop_count  out  DROP_W  events lost to a full FIFO; saturates at all-ones.
- proto_err  out  1  sticky marker-sequence violation.

## Operation
- Marker decode: inst[31:24] == 0, inst[19:0] == 20'h02013, k = inst[23:20], k ≤ 13. Any k ≥ 14 is not a marker and is ignored.
- Phase p = k>>1: 0 VCTM, 1 DELAY, 2 TEXE, 3 LEAK, 4 INIT, 5 BIM, 6 TRAIN. Even k means START, odd k means END.
- Cycle counter: 64-bit, 0 at reset, +1 every clock while reset_n is high; wraps naturally.
- Every valid marker, enqueue or commit, produces one event. Up to two pushes can occur per cycle.
- Push order within a cycle: commit event first, then enqueue event.
- Free slots = DEPTH − occupancy + (evt_valid & evt_ready). A pop frees its slot for same-cycle pushes.
- Insufficient space:
  - One free slot and two markers: the commit event is kept, the enqueue event is dropped.
  - No free slots: both are dropped.
  - drop_count increments by the number of events lost.
- Phase FSM advances on commit markers only. States are NONE and P0..P6.
  - START p from NONE: go to Pp.
  - START p from Pq: set proto_err, go to Pp.
  - END p in Pp: go to NONE.
  - END p in any other state: set proto_err, state unchanged.
- proto_err and drop_count clear only on reset.
- Reset values: evt_valid 0, evt_* fields 0, phase 7, phase_active 0, drop_count 0, proto_err 0. The FIFO is emptied and the counter is zeroed.

## Timing
- Marker sampled at posedge N (valid high). The event is visible on evt_valid at posedge N+1 if the FIFO was empty. evt_cycle equals the counter value during cycle N.
- phase updates at posedge N+1 for a commit marker sampled at posedge N.
- Handshake: the head is held stable while evt_valid && !evt_ready. A pop occurs on evt_valid && evt_ready.
- No combinational path from any input to any output.
- Asserting reset mid-stream discards all queued events immediately; outputs take their reset values asynchronously.

## Configuration
- ROB_MARKER_PC_CAPTURE_EN defined: enq_pc is stored per entry and presented on evt_pc.
- Not defined: the PC is not stored (FIFO entry is 69 bits), evt_pc is tied to 0, and the enq_pc input is unused.

## Structure
- Package rob_marker_pkg holds:
  - MARKER_MASK and MARKER_MATCH constants and MARKER_MAX = 13.
  - Phase enum phase_e (VCTM..TRAIN, NONE = 7).
  - Packed struct marker_evt_t {id, commit, cycle, pc}.
- Sub-module rob_marker_fifo: 2-write/1-read synchronous FIFO with registered head, parameterized by DEPTH and the entry type. It reports free-slot count to the parent.
- The parent holds decode, the cycle counter, drop logic and the phase FSM.

## Test plan
- Enqueue 32'h00802013 at counter 100, then commit it at 105, evt_ready held 1 → two events, {8,0,100,pc} then {8,1,105,0}; phase = INIT from the cycle after commit.
- Same-cycle commit 32'h00102013 and enqueue 32'h00202013, FIFO empty → commit event (id 1) popped before enqueue event (id 2).
- evt_ready 0, push DEPTH+3 single markers → 16 events retained in order, drop_count = 3. Release ready → all 16 drained, evt_valid falls.
- FIFO full with one pop in a cycle where two markers arrive → commit event accepted, enqueue dropped, drop_count +1.
- Commit sequence START 0, START 4, END 0 → proto_err = 1, phase = INIT.
- Assert reset_n low mid-drain with 5 events queued → evt_valid 0, phase 7, drop_count 0 and counter 0 after release.
